// File: rtl/iter_shifter.sv
// ============================================================================
// Module      : iter_shifter
// Description : Multi-cycle SLL/SRL/SRA (optional ROL) shifter, STEP bits per
//               clock, valid/ready on both sides. Define SHIFTER_ROTATE_EN to
//               build rotate-left for mode 11 (otherwise mode 11 acts as SLL).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_shifter #(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 2,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_operand,
    input  logic [AMT_W-1:0] in_amount,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_shift = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam logic [1:0] c_mode_srl = 2'b01;
    localparam logic [1:0] c_mode_sra = 2'b10;
`ifdef SHIFTER_ROTATE_EN
    localparam logic [1:0] c_mode_rol = 2'b11;
`endif

    // Remaining never exceeds WIDTH-1, so clamping STEP there keeps it in AMT_W bits.
    localparam int               c_step_int = (STEP >= WIDTH) ? (WIDTH - 1) : STEP;
    localparam logic [AMT_W-1:0] c_step     = AMT_W'(c_step_int);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [AMT_W-1:0] r_remaining;
    logic [1:0]       r_mode;

    logic [AMT_W-1:0] w_k;
    logic [WIDTH-1:0] w_step_data;
`ifdef SHIFTER_ROTATE_EN
    logic [AMT_W:0]   w_rk;
`endif

    always_comb begin
        w_k = (r_remaining > c_step) ? c_step : r_remaining;
`ifdef SHIFTER_ROTATE_EN
        w_rk = (AMT_W+1)'(WIDTH) - {1'b0, w_k};
`endif
        case (r_mode)
            c_mode_srl: w_step_data = r_data >> w_k;
            c_mode_sra: w_step_data = $unsigned($signed(r_data) >>> w_k);
`ifdef SHIFTER_ROTATE_EN
            c_mode_rol: w_step_data = (r_data << w_k) | (r_data >> w_rk);
`endif
            default:    w_step_data = r_data << w_k;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_data      <= '0;
            r_remaining <= '0;
            r_mode      <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_data      <= in_operand;
                        r_mode      <= in_mode;
                        r_remaining <= in_amount;
                        r_state     <= (in_amount == '0) ? c_st_done : c_st_shift;
                    end
                end
                c_st_shift: begin
                    r_data      <= w_step_data;
                    r_remaining <= r_remaining - w_k;
                    if (r_remaining == w_k) begin
                        r_state <= c_st_done;
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign in_ready   = (r_state == c_st_idle);
    assign out_valid  = (r_state == c_st_done);
    assign out_result = (r_state == c_st_done) ? r_data : '0;
    assign busy       = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_iter_shifter.sv
// ============================================================================
// Module      : tb_iter_shifter
// Description : Randomized and directed bench for iter_shifter with an
//               arithmetic reference model (WIDTH=32, STEP=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_shifter;

    localparam int WIDTH = 32;
    localparam int STEP  = 2;
    localparam int AMT_W = 5;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_operand = '0;
    logic [AMT_W-1:0] in_amount = '0;
    logic [1:0]       in_mode = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_exp  = '0;

    iter_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_operand (in_operand),
        .in_amount  (in_amount),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Result of one shift by the full amount.
    function automatic logic [31:0] ref_shift(input logic [31:0] op, input int amt, input logic [1:0] mode);
        logic [63:0] w;
        logic [63:0] t;
        w = '0;
        t = '0;
        case (mode)
            2'b00: return op << amt;
            2'b01: return op >> amt;
            2'b10: begin
                w = {{32{op[31]}}, op};
                t = w >> amt;
                return t[31:0];
            end
            default: begin
`ifdef SHIFTER_ROTATE_EN
                w = {op, op};
                t = w << amt;
                return t[63:32];
`else
                return op << amt;
`endif
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            m_exp  = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_exp  = ref_shift(in_operand, int'(in_amount), in_mode);
                m_cnt  = (int'(in_amount) + STEP - 1) / STEP;
                m_done = (m_cnt == 0);
            end
        end else if (!m_done) begin
            m_cnt--;
            if (m_cnt == 0) m_done = 1'b1;
        end else if (out_ready) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("in_ready",   {31'd0, in_ready},  {31'd0, !m_busy});
            check("out_valid",  {31'd0, out_valid}, {31'd0, m_done});
            check("busy",       {31'd0, busy},      {31'd0, m_busy});
            check("out_result", out_result,         m_done ? m_exp : 32'd0);
        end
    end

    task automatic do_req(input logic [31:0] op, input int amt, input logic [1:0] mode,
                          input logic [31:0] exp_res, input int exp_lat, input int hold, input string tag);
        int lat;
        @(negedge clock);
        in_valid   = 1'b1;
        in_operand = op;
        in_amount  = AMT_W'(amt);
        in_mode    = mode;
        @(posedge clock);
        @(negedge clock);
        in_valid   = 1'b0;
        in_operand = $urandom;
        in_amount  = AMT_W'($urandom);
        in_mode    = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clock);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, out_result, exp_res);
        check({tag, "_in_ready_done"}, {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            @(negedge clock);
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_result"}, out_result, exp_res);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        #1 reset = 1'b1;
        #3;
        check("rst_in_ready",   {31'd0, in_ready},  32'd1);
        check("rst_out_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_busy",       {31'd0, busy},      32'd0);
        check("rst_out_result", out_result,         32'd0);
        @(negedge clock);
        reset  = 1'b0;
        chk_en = 1'b1;

        check("model_sra31", ref_shift(32'h8000_0000, 31, 2'b10), 32'hFFFF_FFFF);
        check("model_srl31", ref_shift(32'h8000_0000, 31, 2'b01), 32'h0000_0001);

        do_req(32'h0000_0001, 2,  2'b00, 32'h0000_0004, 1,  0, "sll2");
        do_req(32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF, 16, 0, "sra31");
        do_req(32'h8000_0000, 31, 2'b01, 32'h0000_0001, 16, 0, "srl31");
        do_req(32'hDEAD_BEEF, 0,  2'b01, 32'hDEAD_BEEF, 0,  2, "amt0");
        do_req(32'h0000_00FF, 8,  2'b00, 32'h0000_FF00, 4,  5, "bp");
`ifdef SHIFTER_ROTATE_EN
        do_req(32'h8000_0001, 4,  2'b11, 32'h0000_0018, 2,  0, "rol");
`else
        do_req(32'h8000_0001, 4,  2'b11, 32'h0000_0010, 2,  0, "rol");
`endif

        // Asynchronous reset in the middle of a shift.
        @(negedge clock);
        in_valid   = 1'b1;
        in_operand = 32'hFFFF_FFFF;
        in_amount  = AMT_W'(20);
        in_mode    = 2'b01;
        @(posedge clock);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_in_ready",   {31'd0, in_ready},  32'd1);
        check("arst_out_valid",  {31'd0, out_valid}, 32'd0);
        check("arst_busy",       {31'd0, busy},      32'd0);
        check("arst_out_result", out_result,         32'd0);
        @(negedge clock);
        reset = 1'b0;
        do_req(32'h0000_0003, 5, 2'b00, 32'h0000_0060, 3, 1, "post_rst");

        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            in_valid   = ($urandom_range(0, 2) != 0);
            in_operand = $urandom;
            in_amount  = AMT_W'($urandom);
            in_mode    = 2'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
        end
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clock);
        check("drain_idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
